// File: rtl/cv32e40p_ft_fault_manager.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_ft_fault_manager
// Brief    : Consumes TMR voter "detected" flags from the fault-tolerant EX
//            units, requests re-execution on a fault, separates transient
//            from permanent faults, keeps saturating statistics and raises
//            an interrupt when a fault is declared permanent.
// Options  : CV32E40P_FT_TIMESTAMP_EN adds a free-running cycle counter and
//            captures its value at the first fault after reset/clear.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_ft_fault_manager #(
  parameter int N_SRC     = 3,
  parameter int MAX_RETRY = 2,
  parameter int CHECK_WIN = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [N_SRC-1:0] fault_vec_i,
  input  logic             retry_ack_i,
  input  logic             clear_i,
  output logic             retry_req_o,
  output logic             permanent_o,
  output logic             irq_o,
  output logic [N_SRC-1:0] src_sticky_o,
  output logic [CNT_W-1:0] fault_total_o,
  output logic [CNT_W-1:0] transient_cnt_o
`ifdef CV32E40P_FT_TIMESTAMP_EN
  ,
  output logic [31:0]      first_ts_o,
  output logic             ts_valid_o
`endif
);

  localparam int c_RC_W = $clog2(MAX_RETRY + 1);
  localparam int c_TM_W = $clog2(CHECK_WIN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RETRY = 2'd1,
    S_CHECK = 2'd2,
    S_PERM  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [c_RC_W-1:0] r_retry_cnt;
  logic [c_RC_W-1:0] w_retry_cnt_next;
  logic [c_RC_W-1:0] w_retry_cnt_inc;
  logic [c_TM_W-1:0] r_timer;
  logic [c_TM_W-1:0] w_timer_next;
  logic              r_irq;
  logic              w_irq_next;
  logic              w_fault_inc;
  logic              w_trans_inc;
  logic              w_qual;
  logic [N_SRC-1:0]  r_sticky;
  logic [CNT_W-1:0]  r_fault_total;
  logic [CNT_W-1:0]  r_transient;

  // A fault only counts when the EX op actually completes this cycle.
  assign w_qual          = valid_i & (|fault_vec_i);
  assign w_retry_cnt_inc = r_retry_cnt + 1'b1;

  // Next-state and event decode for the retry/check state machine.
  always_comb begin
    w_state_next     = r_state;
    w_retry_cnt_next = r_retry_cnt;
    w_timer_next     = r_timer;
    w_irq_next       = 1'b0;
    w_fault_inc      = 1'b0;
    w_trans_inc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_qual) begin
          w_state_next     = S_RETRY;
          w_retry_cnt_next = '0;
          w_fault_inc      = 1'b1;
        end
      end
      S_RETRY: begin
        // Fault flags are meaningless while the op is being replayed.
        if (retry_ack_i) begin
          w_state_next = S_CHECK;
          w_timer_next = '0;
        end
      end
      S_CHECK: begin
        if (w_qual) begin
          w_fault_inc      = 1'b1;
          w_retry_cnt_next = w_retry_cnt_inc;
          if (w_retry_cnt_inc == c_RC_W'(MAX_RETRY)) begin
            w_state_next = S_PERM;
            w_irq_next   = 1'b1;
          end else begin
            w_state_next = S_RETRY;
          end
        end else if (valid_i) begin
          w_state_next = S_IDLE;
          w_trans_inc  = 1'b1;
        end else if (r_timer == c_TM_W'(CHECK_WIN - 1)) begin
          // Replayed op never came back; treat the fault as transient.
          w_state_next = S_IDLE;
          w_trans_inc  = 1'b1;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      S_PERM: begin
        if (w_qual) begin
          w_fault_inc = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; software clear overrides any event in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_state     <= S_IDLE;
      r_retry_cnt <= '0;
      r_timer     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_retry_cnt <= w_retry_cnt_next;
      r_timer     <= w_timer_next;
      r_irq       <= w_irq_next;
    end
  end

  // Saturating statistics and per-source sticky flags.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_sticky      <= '0;
      r_fault_total <= '0;
      r_transient   <= '0;
    end else begin
      if (w_fault_inc) begin
        r_sticky <= r_sticky | fault_vec_i;
        if (r_fault_total != {CNT_W{1'b1}}) begin
          r_fault_total <= r_fault_total + 1'b1;
        end
      end
      if (w_trans_inc && (r_transient != {CNT_W{1'b1}})) begin
        r_transient <= r_transient + 1'b1;
      end
    end
  end

  assign retry_req_o     = (r_state == S_RETRY);
  assign permanent_o     = (r_state == S_PERM);
  assign irq_o           = r_irq;
  assign src_sticky_o    = r_sticky;
  assign fault_total_o   = r_fault_total;
  assign transient_cnt_o = r_transient;

`ifdef CV32E40P_FT_TIMESTAMP_EN
  logic [31:0] r_ts_cnt;
  logic [31:0] r_first_ts;
  logic        r_ts_valid;

  // Free-running cycle counter; only reset restarts it, clear leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
    end
  end

  // Capture the time of the first counted fault; later faults keep it.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_first_ts <= '0;
      r_ts_valid <= 1'b0;
    end else if (w_fault_inc && !r_ts_valid) begin
      r_first_ts <= r_ts_cnt;
      r_ts_valid <= 1'b1;
    end
  end

  assign first_ts_o = r_first_ts;
  assign ts_valid_o = r_ts_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_ft_fault_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_ft_fault_manager
// Brief    : Self-checking bench for the FT fault manager (CNT_W=4 so that
//            counter saturation is reachable in a short run).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_ft_fault_manager;

  localparam int N_SRC = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i;
  logic [N_SRC-1:0] fault_vec_i;
  logic             retry_ack_i;
  logic             clear_i;
  logic             retry_req_o;
  logic             permanent_o;
  logic             irq_o;
  logic [N_SRC-1:0] src_sticky_o;
  logic [CNT_W-1:0] fault_total_o;
  logic [CNT_W-1:0] transient_cnt_o;
`ifdef CV32E40P_FT_TIMESTAMP_EN
  logic [31:0]      first_ts_o;
  logic             ts_valid_o;
  logic [31:0]      tb_cyc;
`endif

  // {retry_req, permanent, irq, sticky[2:0], fault_total[3:0], transient[3:0]}
  typedef logic [13:0] obs_t;
  typedef struct {
    string name;
    obs_t  val;
  } sb_t;

  sb_t  sb[$];
  obs_t obs;
  int   n_run  = 0;
  int   n_fail = 0;

  assign obs = {retry_req_o, permanent_o, irq_o, src_sticky_o, fault_total_o, transient_cnt_o};

  cv32e40p_ft_fault_manager #(
    .N_SRC    (N_SRC),
    .MAX_RETRY(2),
    .CHECK_WIN(4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .fault_vec_i    (fault_vec_i),
    .retry_ack_i    (retry_ack_i),
    .clear_i        (clear_i),
    .retry_req_o    (retry_req_o),
    .permanent_o    (permanent_o),
    .irq_o          (irq_o),
    .src_sticky_o   (src_sticky_o),
    .fault_total_o  (fault_total_o),
    .transient_cnt_o(transient_cnt_o)
`ifdef CV32E40P_FT_TIMESTAMP_EN
    ,
    .first_ts_o     (first_ts_o),
    .ts_valid_o     (ts_valid_o)
`endif
  );

  always #5 clk = ~clk;

`ifdef CV32E40P_FT_TIMESTAMP_EN
  // Bench-side cycle count, restarted by reset only.
  always @(posedge clk) begin
    if (rst) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end
`endif

  function automatic obs_t mk(input bit rr, input bit pm, input bit irq,
                              input logic [2:0] st, input int tot, input int tr);
    mk = {rr, pm, irq, st, 4'(tot), 4'(tr)};
  endfunction

  // Stimulus word: {rst, clear, ack, valid, vec[2:0]}
  function automatic logic [6:0] s(input bit r, input bit c, input bit a,
                                   input bit v, input logic [2:0] vec);
    s = {r, c, a, v, vec};
  endfunction

  task automatic test_reset();
    logic [6:0] st [2];
    obs_t       ex [2];
    sb_t        e;
    st = '{s(1,0,1,1,3'b111), s(1,0,0,1,3'b111)};
    ex = '{mk(0,0,0,3'b000,0,0), mk(0,0,0,3'b000,0,0)};
    for (int i = 0; i < 2; i++) begin
      {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = st[i];
      sb.push_back('{name:"reset", val:ex[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e.val) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs, e.val);
      end
    end
  endtask

  task automatic test_transient();
    logic [6:0] st [6];
    obs_t       ex [6];
    sb_t        e;
    st = '{s(0,0,0,1,3'b010), s(0,0,0,0,3'b000), s(0,0,1,0,3'b000),
           s(0,0,0,0,3'b000), s(0,0,0,1,3'b000), s(0,0,0,1,3'b000)};
    ex = '{mk(1,0,0,3'b010,1,0), mk(1,0,0,3'b010,1,0), mk(0,0,0,3'b010,1,0),
           mk(0,0,0,3'b010,1,0), mk(0,0,0,3'b010,1,1), mk(0,0,0,3'b010,1,1)};
    for (int i = 0; i < 6; i++) begin
      {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = st[i];
      sb.push_back('{name:"transient", val:ex[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e.val) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs, e.val);
      end
    end
  endtask

  task automatic test_permanent();
    logic [6:0] st [9];
    obs_t       ex [9];
    sb_t        e;
    st = '{s(0,1,0,0,3'b000), s(0,0,0,1,3'b001), s(0,0,1,0,3'b000),
           s(0,0,0,1,3'b100), s(0,0,1,0,3'b000), s(0,0,0,1,3'b001),
           s(0,0,0,0,3'b000), s(0,0,0,1,3'b010), s(0,0,1,0,3'b000)};
    ex = '{mk(0,0,0,3'b000,0,0), mk(1,0,0,3'b001,1,0), mk(0,0,0,3'b001,1,0),
           mk(1,0,0,3'b101,2,0), mk(0,0,0,3'b101,2,0), mk(0,1,1,3'b101,3,0),
           mk(0,1,0,3'b101,3,0), mk(0,1,0,3'b111,4,0), mk(0,1,0,3'b111,4,0)};
    for (int i = 0; i < 9; i++) begin
      {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = st[i];
      sb.push_back('{name:"permanent", val:ex[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e.val) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs, e.val);
      end
    end
  endtask

  task automatic test_masking_priority();
    logic [6:0] st [7];
    obs_t       ex [7];
    sb_t        e;
    st = '{s(0,0,0,0,3'b111), s(0,1,0,1,3'b111), s(0,0,0,0,3'b111),
           s(0,0,1,0,3'b000), s(0,0,0,1,3'b010), s(0,0,0,1,3'b111),
           s(0,1,0,0,3'b000)};
    ex = '{mk(0,1,0,3'b111,4,0), mk(0,0,0,3'b000,0,0), mk(0,0,0,3'b000,0,0),
           mk(0,0,0,3'b000,0,0), mk(1,0,0,3'b010,1,0), mk(1,0,0,3'b010,1,0),
           mk(0,0,0,3'b000,0,0)};
    for (int i = 0; i < 7; i++) begin
      {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = st[i];
      sb.push_back('{name:"mask_prio", val:ex[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e.val) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs, e.val);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] st [7];
    obs_t       ex [7];
    sb_t        e;
    st = '{s(0,0,0,1,3'b100), s(0,0,1,0,3'b000), s(0,0,0,0,3'b000),
           s(0,0,0,0,3'b000), s(0,0,0,0,3'b000), s(0,0,0,0,3'b000),
           s(0,0,0,1,3'b001)};
    ex = '{mk(1,0,0,3'b100,1,0), mk(0,0,0,3'b100,1,0), mk(0,0,0,3'b100,1,0),
           mk(0,0,0,3'b100,1,0), mk(0,0,0,3'b100,1,0), mk(0,0,0,3'b100,1,1),
           mk(1,0,0,3'b101,2,1)};
    for (int i = 0; i < 7; i++) begin
      {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = st[i];
      sb.push_back('{name:"timeout", val:ex[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e.val) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs, e.val);
      end
    end
  endtask

  task automatic test_reset_mid_retry();
    logic [6:0] st [3];
    obs_t       ex [3];
    sb_t        e;
    st = '{s(1,0,0,1,3'b111), s(0,0,0,0,3'b000), s(0,0,1,0,3'b000)};
    ex = '{mk(0,0,0,3'b000,0,0), mk(0,0,0,3'b000,0,0), mk(0,0,0,3'b000,0,0)};
    for (int i = 0; i < 3; i++) begin
      {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = st[i];
      sb.push_back('{name:"rst_mid_retry", val:ex[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if (obs !== e.val) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs, e.val);
      end
    end
  endtask

  task automatic test_saturation();
    sb_t         e;
    logic [31:0] ts_exp;
    ts_exp = 32'd0;
    {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = s(0,1,0,0,3'b000);
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 3; j++) begin
        int tot;
        int tr;
        tot = (k + 1 > 15) ? 15 : k + 1;
        tr  = (k > 15) ? 15 : k;
        if (j == 0) begin
          {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = s(0,0,0,1,3'b001);
          sb.push_back('{name:"saturation", val:mk(1,0,0,3'b001,tot,tr)});
`ifdef CV32E40P_FT_TIMESTAMP_EN
          if (k == 0) ts_exp = tb_cyc;
`endif
        end else if (j == 1) begin
          {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = s(0,0,1,0,3'b000);
          sb.push_back('{name:"saturation", val:mk(0,0,0,3'b001,tot,tr)});
        end else begin
          {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = s(0,0,0,1,3'b000);
          sb.push_back('{name:"saturation", val:mk(0,0,0,3'b001,tot,tot)});
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_run++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s seq %0d step %0d: got %h expected %h", e.name, k, j, obs, e.val);
        end
`ifdef CV32E40P_FT_TIMESTAMP_EN
        if ((k == 0 && j == 2) || (k == 19 && j == 2)) begin
          n_run++;
          if ({ts_valid_o, first_ts_o} !== {1'b1, ts_exp}) begin
            n_fail++;
            $display("FAIL timestamp seq %0d: got valid=%b ts=%0d expected valid=1 ts=%0d",
                     k, ts_valid_o, first_ts_o, ts_exp);
          end
        end
`endif
      end
    end
    {rst, clear_i, retry_ack_i, valid_i, fault_vec_i} = s(0,0,0,0,3'b000);
  endtask

  initial begin
    rst         = 1'b1;
    clear_i     = 1'b0;
    retry_ack_i = 1'b0;
    valid_i     = 1'b0;
    fault_vec_i = '0;
    test_reset();
    test_transient();
    test_permanent();
    test_masking_priority();
    test_timeout();
    test_reset_mid_retry();
    test_saturation();
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
